// File: rtl/video_pattern_gen.sv
// video_pattern_gen: AXI4-Stream test-frame source (solid, colour bars, ramp,
// checkerboard). Emits SOF on tuser and EOL on tlast, honours tready, and
// inserts FRAME_GAP idle cycles between frames. Every output is a flop.
// The next-beat coordinates are resolved combinationally and the pixel for
// that beat is registered, so tready only ever reaches register D inputs.
module video_pattern_gen #(
   parameter int H_ACTIVE  = 16,
   parameter int V_ACTIVE  = 4,
   parameter int FRAME_GAP = 2
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_rgb,
   output logic [23:0] m_axis_video_tdata,
   output logic        m_axis_video_tvalid,
   input  logic        m_axis_video_tready,
   output logic        m_axis_video_tuser,
   output logic        m_axis_video_tlast,
   output logic        frame_done,
   output logic [15:0] frame_count
);

   localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
   localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
   localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
   localparam int          GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

   state_t        state, state_nx;
   logic [11:0]   x, x_nx;
   logic [11:0]   y, y_nx;
   logic [2:0]    bar_idx, bar_idx_nx;
   logic [11:0]   bar_cnt, bar_cnt_nx;
   logic [GW-1:0] gap_cnt, gap_cnt_nx;
   logic [1:0]    cfg_sel, cfg_sel_nx;
   logic [23:0]   cfg_rgb, cfg_rgb_nx;
   logic          valid_nx;
   logic          done_nx;
   logic          start;

   // Pixel value for a coordinate under a given frame configuration.
   // Colour bars use the running bar index, so no divider is needed.
   function automatic logic [23:0] pix(input logic [1:0]  sel,
                                       input logic [23:0] rgb,
                                       input logic [11:0] px,
                                       input logic [11:0] py,
                                       input logic [2:0]  bar);
      logic [23:0] v;
      v = 24'h000000;
      case (sel)
         2'd0: v = rgb;
         2'd1: begin
            case (bar)
               3'd0:    v = 24'hFFFFFF;
               3'd1:    v = 24'hFF00FF;
               3'd2:    v = 24'h00FFFF;
               3'd3:    v = 24'h0000FF;
               3'd4:    v = 24'hFFFF00;
               3'd5:    v = 24'hFF0000;
               3'd6:    v = 24'h00FF00;
               default: v = 24'h000000;
            endcase
         end
         2'd2:    v = {px[7:0], px[7:0], px[7:0]};
         default: v = (px[3] ^ py[3]) ? 24'h000000 : 24'hFFFFFF;
      endcase
      return v;
   endfunction

   // Next state, next coordinates and config relatch at every frame start.
   always_comb begin
      state_nx   = state;
      x_nx       = x;
      y_nx       = y;
      bar_idx_nx = bar_idx;
      bar_cnt_nx = bar_cnt;
      gap_cnt_nx = gap_cnt;
      cfg_sel_nx = cfg_sel;
      cfg_rgb_nx = cfg_rgb;
      valid_nx   = 1'b0;
      done_nx    = 1'b0;
      start      = 1'b0;

      case (state)
         IDLE: begin
            if (enable) begin
               state_nx = ACTIVE;
               start    = 1'b1;
            end
         end

         ACTIVE: begin
            valid_nx = 1'b1;
            if (m_axis_video_tvalid && m_axis_video_tready) begin
               if (x == X_LAST) begin
                  x_nx       = '0;
                  bar_idx_nx = '0;
                  bar_cnt_nx = '0;
                  if (y == Y_LAST) begin
                     y_nx    = '0;
                     done_nx = 1'b1;
                     if (FRAME_GAP > 0) begin
                        state_nx   = GAP;
                        gap_cnt_nx = '0;
                        valid_nx   = 1'b0;
                     end else if (enable) begin
                        // back-to-back: next frame's (0,0) follows with no bubble
                        start = 1'b1;
                     end else begin
                        state_nx = IDLE;
                        valid_nx = 1'b0;
                     end
                  end else begin
                     y_nx = y + 12'd1;
                  end
               end else begin
                  x_nx = x + 12'd1;
                  if (bar_cnt == BAR_LAST) begin
                     bar_cnt_nx = '0;
                     bar_idx_nx = bar_idx + 3'd1;
                  end else begin
                     bar_cnt_nx = bar_cnt + 12'd1;
                  end
               end
            end
         end

         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               if (enable) begin
                  state_nx = ACTIVE;
                  start    = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               gap_cnt_nx = gap_cnt + 1'b1;
            end
         end

         default: state_nx = IDLE;
      endcase

      // A frame start always restarts at (0,0) with freshly sampled config.
      if (start) begin
         valid_nx   = 1'b1;
         x_nx       = '0;
         y_nx       = '0;
         bar_idx_nx = '0;
         bar_cnt_nx = '0;
         cfg_sel_nx = pattern_sel;
         cfg_rgb_nx = solid_rgb;
      end
   end

   // State, coordinate, bar and gap counters, latched frame config.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state   <= IDLE;
         x       <= '0;
         y       <= '0;
         bar_idx <= '0;
         bar_cnt <= '0;
         gap_cnt <= '0;
         cfg_sel <= '0;
         cfg_rgb <= '0;
      end else begin
         state   <= state_nx;
         x       <= x_nx;
         y       <= y_nx;
         bar_idx <= bar_idx_nx;
         bar_cnt <= bar_cnt_nx;
         gap_cnt <= gap_cnt_nx;
         cfg_sel <= cfg_sel_nx;
         cfg_rgb <= cfg_rgb_nx;
      end
   end

   // Registered stream outputs for the beat being presented next cycle.
   // During a stall the next coordinates equal the current ones, so the
   // recomputed beat is identical and the outputs stay stable.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_axis_video_tdata  <= '0;
         m_axis_video_tvalid <= 1'b0;
         m_axis_video_tuser  <= 1'b0;
         m_axis_video_tlast  <= 1'b0;
      end else begin
         m_axis_video_tvalid <= valid_nx;
         m_axis_video_tdata  <= valid_nx ? pix(cfg_sel_nx, cfg_rgb_nx, x_nx, y_nx, bar_idx_nx) : 24'h000000;
         m_axis_video_tuser  <= valid_nx && (x_nx == 12'd0) && (y_nx == 12'd0);
         m_axis_video_tlast  <= valid_nx && (x_nx == X_LAST);
      end
   end

   // Frame completion pulse and wrapping completed-frame counter.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_done <= done_nx;
         if (done_nx) frame_count <= frame_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: two instances (16x4 gap 2, 16x16 gap 0) share
// stimulus; each is compared every cycle against a frame-level model that
// tracks a linear beat index and derives pixels arithmetically.
module tb_video_pattern_gen;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        enable = 1'b0;
   logic        tready = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [23:0] rgb = 24'h0;

   logic [23:0] a_data, b_data;
   logic        a_valid, a_user, a_last, a_done;
   logic        b_valid, b_user, b_last, b_done;
   logic [15:0] a_cnt, b_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   video_pattern_gen #(.H_ACTIVE(16), .V_ACTIVE(4), .FRAME_GAP(2)) dut_a (
      .aclk(aclk), .areset(areset), .enable(enable), .pattern_sel(sel), .solid_rgb(rgb),
      .m_axis_video_tdata(a_data), .m_axis_video_tvalid(a_valid), .m_axis_video_tready(tready),
      .m_axis_video_tuser(a_user), .m_axis_video_tlast(a_last),
      .frame_done(a_done), .frame_count(a_cnt));

   video_pattern_gen #(.H_ACTIVE(16), .V_ACTIVE(16), .FRAME_GAP(0)) dut_b (
      .aclk(aclk), .areset(areset), .enable(enable), .pattern_sel(sel), .solid_rgb(rgb),
      .m_axis_video_tdata(b_data), .m_axis_video_tvalid(b_valid), .m_axis_video_tready(tready),
      .m_axis_video_tuser(b_user), .m_axis_video_tlast(b_last),
      .frame_done(b_done), .frame_count(b_cnt));

   // phase: 0 idle, 1 streaming, 2 inter-frame gap; k = beat index in frame
   typedef struct {
      int          phase;
      int          k;
      int          gap;
      logic [1:0]  sel;
      logic [23:0] rgb;
      bit          done;
      int          fc;
   } mdl_t;

   mdl_t ma, mb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] ref_pix(input int h, input logic [1:0] s,
                                           input logic [23:0] c, input int x, input int y);
      logic [7:0] r;
      case (s)
         2'd0: return c;
         2'd1: begin
            case (x / (h / 8))
               0: return 24'hFFFFFF;
               1: return 24'hFF00FF;
               2: return 24'h00FFFF;
               3: return 24'h0000FF;
               4: return 24'hFFFF00;
               5: return 24'hFF0000;
               6: return 24'h00FF00;
               default: return 24'h000000;
            endcase
         end
         2'd2: begin
            r = 8'(x % 256);
            return {r, r, r};
         end
         default: return ((((x / 8) + (y / 8)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
      endcase
   endfunction

   task automatic model_reset(inout mdl_t m);
      m.phase = 0; m.k = 0; m.gap = 0; m.sel = 2'd0; m.rgb = 24'h0; m.done = 1'b0; m.fc = 0;
   endtask

   task automatic model_begin(inout mdl_t m);
      m.phase = 1; m.k = 0; m.sel = sel; m.rgb = rgb;
   endtask

   // One clock of the stream behaviour, using inputs as seen at the edge.
   task automatic model_step(input int h, input int v, input int g, inout mdl_t m);
      m.done = 1'b0;
      case (m.phase)
         0: if (enable) model_begin(m);
         1: begin
            if (tready) begin
               if (m.k == h * v - 1) begin
                  m.done = 1'b1;
                  m.fc   = (m.fc + 1) % 65536;
                  m.k    = 0;
                  if (g > 0) begin
                     m.phase = 2;
                     m.gap   = g;
                  end else if (enable) model_begin(m);
                  else m.phase = 0;
               end else begin
                  m.k++;
               end
            end
         end
         default: begin
            m.gap--;
            if (m.gap == 0) begin
               if (enable) model_begin(m);
               else m.phase = 0;
            end
         end
      endcase
   endtask

   task automatic check_dut(input string nm, input int h, input mdl_t m,
                            input logic v, input logic u, input logic l, input logic d,
                            input logic [23:0] td, input logic [15:0] fc);
      logic ev;
      ev = (m.phase == 1);
      chk({nm, ".tvalid"}, 32'(v), 32'(ev));
      if (ev) begin
         chk({nm, ".tuser"}, 32'(u), 32'(m.k == 0));
         chk({nm, ".tlast"}, 32'(l), 32'((m.k % h) == h - 1));
         chk({nm, ".tdata"}, 32'(td), 32'(ref_pix(h, m.sel, m.rgb, m.k % h, m.k / h)));
      end
      chk({nm, ".frame_done"}, 32'(d), 32'(m.done));
      chk({nm, ".frame_count"}, 32'(fc), 32'(m.fc));
   endtask

   // Advance one clock: update models at the edge, compare on the falling edge.
   task automatic tick();
      @(posedge aclk);
      if (areset) begin
         model_reset(ma);
         model_reset(mb);
      end else begin
         model_step(16, 4, 2, ma);
         model_step(16, 16, 0, mb);
      end
      @(negedge aclk);
      check_dut("A", 16, ma, a_valid, a_user, a_last, a_done, a_data, a_cnt);
      check_dut("B", 16, mb, b_valid, b_user, b_last, b_done, b_data, b_cnt);
   endtask

   // Assert reset between edges and confirm outputs clear without a clock.
   task automatic async_reset();
      areset = 1'b1;
      #1;
      chk("A.rst_tdata", 32'(a_data), 32'd0);
      chk("A.rst_tvalid", 32'(a_valid), 32'd0);
      chk("A.rst_tuser", 32'(a_user), 32'd0);
      chk("A.rst_tlast", 32'(a_last), 32'd0);
      chk("A.rst_count", 32'(a_cnt), 32'd0);
      chk("B.rst_tvalid", 32'(b_valid), 32'd0);
      chk("B.rst_count", 32'(b_cnt), 32'd0);
      model_reset(ma);
      model_reset(mb);
      tick();
      areset = 1'b0;
   endtask

   initial begin
      model_reset(ma);
      model_reset(mb);
      tick();
      tick();
      areset = 1'b0;
      tick();

      // colour bars, no backpressure
      sel = 2'd1; enable = 1'b1; tready = 1'b1;
      repeat (80) tick();

      // solid colour with tready pattern 1,0,0,1
      sel = 2'd0; rgb = 24'h123456;
      for (int i = 0; i < 300; i++) begin
         tready = (i % 4 == 0) || (i % 4 == 3);
         tick();
      end

      // change colour and drop enable at beat 20 of a frame
      tready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (ma.phase == 1 && ma.k == 20) break;
         tick();
      end
      rgb = 24'hABCDEF; enable = 1'b0;
      repeat (300) tick();

      // reset in the middle of a ramp frame
      sel = 2'd2; enable = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (ma.phase == 1 && ma.k == 30) break;
         tick();
      end
      async_reset();
      repeat (40) tick();

      // checkerboard across full 16x16 frames, back-to-back on instance B
      sel = 2'd3;
      repeat (600) tick();

      // randomized run
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 15) != 0);
         tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 31) == 0) sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) rgb = 24'($urandom);
         if (i == 1500) async_reset();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
AXI4-Stream video transmitter that synthesises test frames (solid colour, colour bars, ramp, checkerboard) for the video pipeline. It drives the slave side of the greyscale filter, or v_axi4s_vid_out, in place of the v_vid_in_axi4s source. It emits SOF on tuser and EOL on tlast, honours tready backpressure, and inserts a programmable idle gap between frames.

Parameters:
H_ACTIVE, 16, active pixels per line; multiple of 8, >= 8, <= 4096
V_ACTIVE, 4, active lines per frame; >= 1, <= 4096
FRAME_GAP, 2, idle cycles (tvalid=0) between frames; 0 = back-to-back

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous active-high reset
enable  in  1  run request; level-sensitive
pattern_sel  in  2  0=solid, 1=colour bars, 2=horizontal ramp, 3=checkerboard
solid_rgb  in  24  solid colour, packed {R[23:16],B[15:8],G[7:0]}
m_axis_video_tdata  out  24  pixel, packed {R,B,G}
m_axis_video_tvalid  out  1  beat valid
m_axis_video_tready  in  1  sink ready
m_axis_video_tuser  out  1  start of frame; pixel (0,0) only
m_axis_video_tlast  out  1  end of line; x = H_ACTIVE-1
frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted
frame_count  out  16  completed frames, wraps 65535->0

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE. x=y=0. All outputs 0, including tdata, tvalid, tuser, tlast, frame_done and frame_count. Reset mid-frame aborts the frame immediately with no tlast completion.
- All outputs are registered. No combinational path from tready to any output.
- FSM states: IDLE, ACTIVE, GAP.
  - IDLE: while enable=0, stay and hold tvalid=0. When enable=1, latch pattern_sel and solid_rgb, go to ACTIVE, and present pixel (0,0) with tuser=1 on the next cycle.
  - ACTIVE: tvalid=1. A beat transfers when tvalid & tready.
    - Without a transfer, tdata, tuser and tlast hold stable.
    - On a transfer, advance x; at x=H_ACTIVE-1, set x=0 and y=y+1.
    - On transfer of (H_ACTIVE-1, V_ACTIVE-1): pulse frame_done and increment frame_count on the next cycle.
    - If FRAME_GAP>0, go to GAP (tvalid=0).
    - If FRAME_GAP=0 and enable=1, relatch config and present (0,0) with tuser=1 on the very next cycle, with no bubble.
    - If FRAME_GAP=0 and enable=0, go to IDLE.
  - GAP: tvalid=0 for exactly FRAME_GAP cycles. Then, if enable=1, relatch config and enter ACTIVE with (0,0) presented; otherwise go to IDLE.
- enable deasserted mid-frame: the current frame completes in full, then the block goes to IDLE after the gap (if any). Frames are never truncated.
- pattern_sel and solid_rgb changes mid-frame have no effect until the next frame start.
- tuser=1 only when x=0,y=0. tlast=1 only when x=H_ACTIVE-1, on every line including the last.
- Pixel rules (tdata packed {R,B,G}):
  - 0 solid: tdata = latched solid_rgb.
  - 1 bars: bar = x / (H_ACTIVE/8), range 0..7. Use a bar-width counter, not a divider.
    - Bar order and tdata: white 0xFFFFFF, yellow 0xFF00FF, cyan 0x00FFFF, green 0x0000FF, magenta 0xFFFF00, red 0xFF0000, blue 0x00FF00, black 0x000000.
  - 2 ramp: R=B=G=x[7:0]. Wraps every 256 pixels.
  - 3 checker: white 0xFFFFFF if (x[3] XOR y[3])=0, else black 0x000000. Squares are 8x8.
- Counters: x is 12 bits and y is 12 bits. No out-of-range value is reachable.

Test Plan:
- Default params, pattern 1, enable=1, tready=1: 64 beats. Line 0 tdata = FFFFFF,FFFFFF,FF00FF,FF00FF,...,000000,000000. tuser only on beat 0. tlast on beats 15,31,47,63. frame_done at cycle after beat 63. Then 2 idle cycles, then tuser again. frame_count=1.
- Pattern 0, solid_rgb=0x123456, tready toggled 1,0,0,1 repeatedly: 64 accepted beats all 0x123456. tdata, tuser and tlast stable during every tready=0 cycle. No beat is lost or duplicated.
- FRAME_GAP=0, pattern 2, enable held: frame 2 pixel (0,0) with tuser=1 appears the cycle after frame 1's last handshake. Ramp reads 00..0F per line.
- solid_rgb changed and enable dropped at beat 20 of a frame: the frame finishes all 64 beats with the old colour. tvalid=0 after the gap. State is IDLE with frame_count incremented.
- areset pulsed at beat 30: all outputs 0 asynchronously. After release with enable=1, the next beat is (0,0) with tuser=1. frame_count=0.
- Pattern 3, H_ACTIVE=16, V_ACTIVE=16: pixel (7,0)=FFFFFF, (8,0)=000000, (0,8)=000000, (8,8)=FFFFFF.
